soc_system_sysid_checker: RTL and testbench

Avalon-MM initiator that reads the system-ID responder at boot or on request and checks it against the build-time expected values. It issues reads to word 0 (system ID) and word 1 (build timestamp), captures both words, and reports pass/fail, mismatch and timeout flags. It sits in the FPGA fabric beside the ID responder, so logic can refuse to run against a mismatched HPS software image.

---
 rtl/soc_system_sysid_pkg.sv | 19 +
 rtl/soc_system_sysid_checker.sv | 213 +++++++++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_DONE
  } sysid_state_e;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'hACD5_1302;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5909_D49C;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM initiator that reads the system-ID responder and compares it with build-time values.
// Define SYSID_CHECK_TIMESTAMP_EN to also read and compare the build timestamp (word 1).
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  LAT_LIM     = 2'(READ_LATENCY);

  sysid_state_e state_q, state_d;
  logic [15:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]   lat_cnt_q, lat_cnt_d;
  logic         avm_read_q, avm_read_d;
  logic         avm_address_q, avm_address_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic         id_mismatch_q, id_mismatch_d;
  logic         timeout_q, timeout_d;
  logic [31:0]  id_value_q, id_value_d;
`ifdef SYSID_CHECK_TIMESTAMP_EN
  logic         ts_mismatch_q, ts_mismatch_d;
  logic [31:0]  ts_value_q, ts_value_d;
  logic         cap_ts;
`endif

  logic accepted, stalled, cap_id, abort, ts_bad;

  // waitrequest only matters while a read is actually being presented
  assign accepted = avm_read_q & ~avm_waitrequest;
  assign stalled  = avm_read_q & avm_waitrequest;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    pass_d        = pass_q;
    id_mismatch_d = id_mismatch_q;
    timeout_d     = timeout_q;
    id_value_d    = id_value_q;
    cap_id        = 1'b0;
    abort         = 1'b0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
    ts_mismatch_d = ts_mismatch_q;
    ts_value_d    = ts_value_q;
    cap_ts        = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_RD_ID;
          wait_cnt_d    = '0;
          pass_d        = 1'b0;
          id_mismatch_d = 1'b0;
          timeout_d     = 1'b0;
          id_value_d    = '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
          ts_mismatch_d = 1'b0;
          ts_value_d    = '0;
`endif
        end
      end
      ST_RD_ID: begin
        if (accepted) begin
          if (READ_LATENCY == 0) begin
            cap_id = 1'b1;
          end else begin
            state_d   = ST_LAT_ID;
            lat_cnt_d = 2'd1;
          end
        end else if (stalled) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          abort      = (wait_cnt_d == TIMEOUT_LIM);
        end
      end
      ST_LAT_ID: begin
        if (lat_cnt_q == LAT_LIM) cap_id = 1'b1;
        else                      lat_cnt_d = lat_cnt_q + 2'd1;
      end
`ifdef SYSID_CHECK_TIMESTAMP_EN
      ST_RD_TS: begin
        if (accepted) begin
          if (READ_LATENCY == 0) begin
            cap_ts = 1'b1;
          end else begin
            state_d   = ST_LAT_TS;
            lat_cnt_d = 2'd1;
          end
        end else if (stalled) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          abort      = (wait_cnt_d == TIMEOUT_LIM);
        end
      end
      ST_LAT_TS: begin
        if (lat_cnt_q == LAT_LIM) cap_ts = 1'b1;
        else                      lat_cnt_d = lat_cnt_q + 2'd1;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (cap_id) begin
      id_value_d    = avm_readdata;
      id_mismatch_d = (avm_readdata != EXPECTED_ID);
`ifdef SYSID_CHECK_TIMESTAMP_EN
      state_d       = ST_RD_TS;
      wait_cnt_d    = '0;
`else
      state_d       = ST_DONE;
`endif
    end

`ifdef SYSID_CHECK_TIMESTAMP_EN
    if (cap_ts) begin
      ts_value_d    = avm_readdata;
      ts_mismatch_d = (avm_readdata != EXPECTED_TS);
      state_d       = ST_DONE;
    end
    ts_bad = ts_mismatch_d;
`else
    ts_bad = 1'b0;
`endif

    if (abort) begin
      timeout_d = 1'b1;
      state_d   = ST_DONE;
    end

    // the verdict is settled on the way into DONE so it is valid alongside the done pulse
    if (state_d == ST_DONE) pass_d = ~timeout_d & ~id_mismatch_d & ~ts_bad;

    avm_read_d    = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
    avm_address_d = (state_d == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      lat_cnt_q     <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= SYSID_ADDR_ID;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_mismatch_q <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
      ts_mismatch_q <= 1'b0;
      ts_value_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      id_mismatch_q <= id_mismatch_d;
      timeout_q     <= timeout_d;
      id_value_q    <= id_value_d;
`ifdef SYSID_CHECK_TIMESTAMP_EN
      ts_mismatch_q <= ts_mismatch_d;
      ts_value_q    <= ts_value_d;
`endif
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mismatch_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
`ifdef SYSID_CHECK_TIMESTAMP_EN
  assign ts_mismatch = ts_mismatch_q;
  assign ts_value    = ts_value_q;
`else
  assign ts_mismatch = 1'b0;
  assign ts_value    = '0;
`endif

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench: two checker instances (latency 0 and 2, timeout 8) each driven by a small responder.
`timescale 1ns/1ps
module tb_soc_system_sysid_checker;

  localparam logic [31:0] GOOD_ID = 32'hACD5_1302;
  localparam logic [31:0] GOOD_TS = 32'h5909_D49C;
`ifdef SYSID_CHECK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef struct packed {
    logic        read;
    logic        addr;
    logic        busy;
    logic        done;
    logic        pass;
    logic        idm;
    logic        tsm;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  start_v = 2'b00;
  logic [31:0] id_word = GOOD_ID;
  logic [31:0] ts_word = GOOD_TS;
  int          stall_n = 0;
  logic        force_wait = 1'b0;
  logic        sel = 1'b0;
  obs_t [1:0]  obs;
  obs_t        o;

  always #5 clock = ~clock;
  assign o = obs[sel];

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = gi * 2;
    logic        rd, ad, wt, acc, bz, dn, ps, idm, tsm, to;
    logic [31:0] rdata, idv, tsv;
    logic [2:0]  pv, pa;
    logic [7:0]  scnt;

    assign acc = rd & ~wt;
    assign wt  = rd & (force_wait | (int'(scnt) < stall_n));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        scnt <= 8'd0;
        pv   <= 3'b000;
        pa   <= 3'b000;
      end else begin
        scnt <= (!rd || acc) ? 8'd0 : scnt + 8'd1;
        pv   <= {pv[1:0], acc};
        pa   <= {pa[1:0], ad};
      end
    end

    // data is only valid in the exact return cycle; anything else reads as a poison word
    if (LAT == 0) begin : g_l0
      assign rdata = acc ? (ad ? ts_word : id_word) : 32'hDEAD_BEEF;
    end else begin : g_lat
      assign rdata = pv[LAT-1] ? (pa[LAT-1] ? ts_word : id_word) : 32'hDEAD_BEEF;
    end

    soc_system_sysid_checker #(
      .READ_LATENCY  (LAT),
      .TIMEOUT_CYCLES(8)
    ) u_dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start_v[gi]),
      .avm_address    (ad),
      .avm_read       (rd),
      .avm_waitrequest(wt),
      .avm_readdata   (rdata),
      .busy           (bz),
      .done           (dn),
      .pass           (ps),
      .id_mismatch    (idm),
      .ts_mismatch    (tsm),
      .timeout        (to),
      .id_value       (idv),
      .ts_value       (tsv)
    );

    assign obs[gi] = {rd, ad, bz, dn, ps, idm, tsm, to, idv, tsv};
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int   done_cyc, done_cnt, rd0_cnt, rd1_cnt;
  logic rd_at1, rd_at_done, busy_end;

  task automatic run(input string name, input logic inst, input int extra_start, input bit start_in_done);
    sel      = inst;
    done_cyc = -1;
    done_cnt = 0;
    rd0_cnt  = 0;
    rd1_cnt  = 0;
    rd_at1   = 1'b0;
    rd_at_done = 1'b1;
    @(negedge clock);
    start_v[inst] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      start_v[inst] = 1'b0;
      if (n == 1) rd_at1 = o.read;
      if (o.read && !o.addr) rd0_cnt++;
      if (o.read && o.addr)  rd1_cnt++;
      if (o.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc   = n;
          rd_at_done = o.read;
        end
        if (start_in_done) start_v[inst] = 1'b1;
      end
      if (n == extra_start) start_v[inst] = 1'b1;
    end
    @(negedge clock);
    start_v[inst] = 1'b0;
    busy_end = o.busy;
    $display("run %-10s inst=%0d done@%0d pulses=%0d pass=%0b idm=%0b tsm=%0b to=%0b id=%h ts=%h",
             name, inst, done_cyc, done_cnt, o.pass, o.idm, o.tsm, o.to, o.idv, o.tsv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (2) @(negedge clock);
    check_eq("rst_read", 32'(o.read), 32'd0);
    check_eq("rst_addr", 32'(o.addr), 32'd0);
    check_eq("rst_busy", 32'(o.busy), 32'd0);
    check_eq("rst_done", 32'(o.done), 32'd0);
    check_eq("rst_pass", 32'(o.pass), 32'd0);
    check_eq("rst_flags", 32'({o.idm, o.tsm, o.to}), 32'd0);
    check_eq("rst_idv", o.idv, 32'd0);
    check_eq("rst_tsv", o.tsv, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // good words, latency 0, no stalls
    run("good_l0", 1'b0, 0, 1'b0);
    check_eq("good_done_cyc", 32'(done_cyc), TS_EN ? 32'd3 : 32'd2);
    check_eq("good_read_c1", 32'(rd_at1), 32'd1);
    check_eq("good_pulses", 32'(done_cnt), 32'd1);
    check_eq("good_pass", 32'(o.pass), 32'd1);
    check_eq("good_flags", 32'({o.idm, o.tsm, o.to}), 32'd0);
    check_eq("good_idv", o.idv, GOOD_ID);
    check_eq("good_tsv", o.tsv, TS_EN ? GOOD_TS : 32'd0);
    check_eq("good_rd1", 32'(rd1_cnt), TS_EN ? 32'd1 : 32'd0);
    check_eq("good_busy_end", 32'(busy_end), 32'd0);

    // wrong ID word
    id_word = 32'hACD5_1303;
    run("bad_id", 1'b0, 0, 1'b0);
    check_eq("badid_idm", 32'(o.idm), 32'd1);
    check_eq("badid_pass", 32'(o.pass), 32'd0);
    check_eq("badid_tsm", 32'(o.tsm), 32'd0);
    check_eq("badid_idv", o.idv, 32'hACD5_1303);
    id_word = GOOD_ID;

    // wrong timestamp word
    ts_word = 32'h5909_D49D;
    run("bad_ts", 1'b0, 0, 1'b0);
    check_eq("badts_tsm", 32'(o.tsm), TS_EN ? 32'd1 : 32'd0);
    check_eq("badts_pass", 32'(o.pass), TS_EN ? 32'd0 : 32'd1);
    check_eq("badts_idm", 32'(o.idm), 32'd0);
    check_eq("badts_tsv", o.tsv, TS_EN ? 32'h5909_D49D : 32'd0);
    ts_word = GOOD_TS;

    // permanent stall: abort after the 8th stall cycle
    force_wait = 1'b1;
    run("timeout", 1'b0, 0, 1'b0);
    check_eq("to_done_cyc", 32'(done_cyc), 32'd9);
    check_eq("to_timeout", 32'(o.to), 32'd1);
    check_eq("to_pass", 32'(o.pass), 32'd0);
    check_eq("to_read_at_done", 32'(rd_at_done), 32'd0);
    check_eq("to_idv_cleared", o.idv, 32'd0);
    check_eq("to_rd0_cycles", 32'(rd0_cnt), 32'd8);
    force_wait = 1'b0;

    // one stall short of the limit on each read
    stall_n = 7;
    run("stall7", 1'b0, 0, 1'b0);
    check_eq("st7_done_cyc", 32'(done_cyc), TS_EN ? 32'd17 : 32'd9);
    check_eq("st7_timeout", 32'(o.to), 32'd0);
    check_eq("st7_pass", 32'(o.pass), 32'd1);

    // latency 2 with 3 stalls per read
    stall_n = 3;
    run("lat2_st3", 1'b1, 0, 1'b0);
    check_eq("l2_done_cyc", 32'(done_cyc), TS_EN ? 32'd13 : 32'd7);
    check_eq("l2_pass", 32'(o.pass), 32'd1);
    check_eq("l2_rd0_cycles", 32'(rd0_cnt), 32'd4);
    check_eq("l2_rd1_cycles", 32'(rd1_cnt), TS_EN ? 32'd4 : 32'd0);
    check_eq("l2_idv", o.idv, GOOD_ID);
    check_eq("l2_tsv", o.tsv, TS_EN ? GOOD_TS : 32'd0);

    // start pulses while busy and in the DONE cycle are ignored
    run("start_ign", 1'b0, TS_EN ? 6 : 2, 1'b1);
    check_eq("ign_done_cyc", 32'(done_cyc), TS_EN ? 32'd9 : 32'd5);
    check_eq("ign_pulses", 32'(done_cnt), 32'd1);
    check_eq("ign_busy_end", 32'(busy_end), 32'd0);
    check_eq("ign_pass", 32'(o.pass), 32'd1);
    stall_n = 0;

    // reset asserted while waiting in LAT_ID
    sel = 1'b1;
    @(negedge clock);
    start_v[1] = 1'b1;
    @(negedge clock);
    start_v[1] = 1'b0;
    @(negedge clock);
    check_eq("mid_busy", 32'(o.busy), 32'd1);
    check_eq("mid_read", 32'(o.read), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_eq("mrst_read", 32'(o.read), 32'd0);
    check_eq("mrst_busy", 32'(o.busy), 32'd0);
    check_eq("mrst_done", 32'(o.done), 32'd0);
    check_eq("mrst_idv", o.idv, 32'd0);
    check_eq("mrst_pass", 32'(o.pass), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("mrst_done_after", 32'(o.done), 32'd0);
    $display("run %-10s inst=1 reset during LAT_ID", "mid_reset");
    run("after_rst", 1'b1, 0, 1'b0);
    check_eq("ar_done_cyc", 32'(done_cyc), TS_EN ? 32'd7 : 32'd4);
    check_eq("ar_pass", 32'(o.pass), 32'd1);
    check_eq("ar_tsv", o.tsv, TS_EN ? GOOD_TS : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
